voq_rd_sched: RTL and testbench
===============================

Name: voq_rd_sched

Overview:
Read-side scheduler for the per-output set of VOQs. Tracks occupancy of NUM_VOQ VOQs by tapping their write strobes and picks a non-empty VOQ round-robin. Issues the one-cycle read request, captures the returned buffer pointer and flood flag, and presents it to the egress stage on a valid/ready handshake. One instance sits per output port, between the VOQ bank and egress frame fetch.

Parameters:
NUM_VOQ, 4, number of VOQs served (one per ingress port); must be >= 2
ADDR_W, mem_pkg::ADDR_W, buffer pointer width
VOQ_DEPTH, voq_pkg::VOQ_DEPTH, entries per VOQ; occupancy counter width CNT_W = $clog2(VOQ_DEPTH+1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
voq_write_i  in  NUM_VOQ  copy of each VOQ's write_req_i
read_req_o  out  NUM_VOQ  to each VOQ read_req_i; at most one bit high
voq_ptr_i  in  NUM_VOQ*ADDR_W  VOQ ptr_o, VOQ k at bits [k*ADDR_W +: ADDR_W]
voq_ptr_valid_i  in  NUM_VOQ  VOQ ptr_valid_o
voq_flood_i  in  NUM_VOQ  VOQ flood_o
ptr_o  out  ADDR_W  granted buffer pointer
flood_o  out  1  flood flag of granted pointer
src_o  out  $clog2(NUM_VOQ)  index of the VOQ that supplied ptr_o
valid_o  out  1  ptr_o/flood_o/src_o valid
ready_i  in  1  egress accepts when valid_o && ready_i
err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, all counters 0, RR pointer 0, read_req_o=0, valid_o=0, ptr_o=0, flood_o=0, src_o=0, err_o=0. Reset mid-operation abandons any grant. The VOQ bank shares rst_n.
- Occupancy cnt[k]: next = cnt[k] + voq_write_i[k] - rd[k]. rd[k] is read_req_o[k] in the current cycle. Write and read on the same VOQ in the same cycle leave the count unchanged.
- Write when cnt[k]==VOQ_DEPTH and no read: count holds (the VOQ drops the entry).
- Eligible[k] = (cnt[k] != 0). Registered counts only; same-cycle writes are not eligible.
- FSM:
  - IDLE: if any eligible, latch grant g = first eligible index searching from rr_ptr upward with wrap. Go to ISSUE. Otherwise stay.
  - ISSUE: read_req_o[g]=1 for exactly this cycle. Go to WAIT.
  - WAIT: voq_ptr_valid_i[g] is required this cycle (VOQ 1-cycle latency).
    - If present: register ptr_o, flood_o, src_o=g, set valid_o=1, go to HOLD.
    - If absent: set err_o=1, go to IDLE, output nothing.
  - HOLD: hold outputs stable while ready_i=0. On ready_i=1: valid_o=0, rr_ptr = g+1 mod NUM_VOQ, go to IDLE.
- Throughput: one pointer per 4 cycles with ready_i held high. Latency from IDLE with an eligible VOQ to valid_o is 3 cycles.
- voq_ptr_valid_i[k] high for k != g in any cycle, or any bit high outside WAIT: set err_o=1 and ignore.
- err_o clears only on reset.
- Counter underflow is impossible by construction: reads are issued only when cnt>0.

Optional Feature:
VOQ_RD_SCHED_STRICT_PRI_EN:
- Defined: IDLE grants the lowest-index eligible VOQ (fixed priority) and rr_ptr is unused.
- Undefined: round-robin as above.
- All other behaviour is identical.

Test Plan:
- Reset, then voq_write_i=4'b0100 for 1 cycle, ready_i=1, VOQ2 model returns ptr 0x1A, flood 0 -> read_req_o=4'b0100 for 1 cycle; valid_o 3 cycles after IDLE with ptr_o=0x1A, src_o=2, flood_o=0; cnt[2] back to 0.
- VOQ0 and VOQ1 each loaded with 2 entries, ready_i=1 -> grants in order src 0,1,0,1. With VOQ_RD_SCHED_STRICT_PRI_EN defined, order is 0,0,1,1.
- ready_i=0 for 5 cycles while valid_o=1 -> ptr_o, flood_o, src_o stable and no new read_req_o. ready_i=1 -> valid_o drops the next cycle.
- Same-cycle voq_write_i[3]=1 during ISSUE to VOQ3 with cnt[3]=1 -> cnt[3] stays 1 and a second grant to VOQ3 follows.
- VOQ model withholds ptr_valid in WAIT -> err_o=1 sticky, FSM returns to IDLE. Stray voq_ptr_valid_i[1] while idle -> err_o=1.
- VOQ_DEPTH writes plus 1 extra to VOQ0 with no reads -> cnt[0]=VOQ_DEPTH. Reset asserted during HOLD -> valid_o=0, counts 0 on the next cycle.

Source files
------------

// File: rtl/voq_rd_sched.sv
// Read-side scheduler for one output's VOQ set: tracks occupancy, grants a non-empty VOQ,
// fetches its pointer and hands it to egress. Define VOQ_RD_SCHED_STRICT_PRI_EN for fixed priority.
module voq_rd_sched #(
    parameter int NUM_VOQ   = 4,
    parameter int ADDR_W    = 8,
    parameter int VOQ_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_VOQ-1:0]         voq_write_i,
    output logic [NUM_VOQ-1:0]         read_req_o,
    input  logic [NUM_VOQ*ADDR_W-1:0]  voq_ptr_i,
    input  logic [NUM_VOQ-1:0]         voq_ptr_valid_i,
    input  logic [NUM_VOQ-1:0]         voq_flood_i,
    output logic [ADDR_W-1:0]          ptr_o,
    output logic                       flood_o,
    output logic [$clog2(NUM_VOQ)-1:0] src_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       err_o
);

    localparam int SRC_W = $clog2(NUM_VOQ);
    localparam int CNT_W = $clog2(VOQ_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    state_t             state, state_nxt;
    logic [SRC_W-1:0]   grant;
    logic [SRC_W-1:0]   pick;
    logic               any_elig;
    logic [NUM_VOQ-1:0] elig;
    logic [NUM_VOQ-1:0] grant_oh;
    logic [CNT_W-1:0]   cnt [NUM_VOQ];
    logic               missing;
    logic               stray;

    assign grant_oh = NUM_VOQ'(1) << grant;
    assign missing  = (state == S_WAIT) && !voq_ptr_valid_i[grant];
    assign stray    = (state == S_WAIT) ? |(voq_ptr_valid_i & ~grant_oh) : |voq_ptr_valid_i;

    // Occupancy per VOQ; a write to a full VOQ is dropped by the VOQ, so the count holds.
    for (genvar k = 0; k < NUM_VOQ; k++) begin : g_cnt
        // NOTE: the counters are a handful of flops, not a RAM, so they take the reset like any register.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt[k] <= '0;
            end else begin
                case ({voq_write_i[k], read_req_o[k]})
                    2'b10:   if (cnt[k] != CNT_W'(VOQ_DEPTH)) cnt[k] <= cnt[k] + CNT_W'(1);
                    2'b01:   cnt[k] <= cnt[k] - CNT_W'(1);
                    default: cnt[k] <= cnt[k];
                endcase
            end
        end
        assign elig[k] = (cnt[k] != '0);
    end

`ifdef VOQ_RD_SCHED_STRICT_PRI_EN
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        pick     = '0;
        any_elig = |elig;
        for (int i = NUM_VOQ - 1; i >= 0; i--) begin
            if (elig[i]) pick = SRC_W'(i);
        end
    end
`else
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] idx;

    // Reverse scan so the last hit is the first eligible VOQ at or after rr_ptr.
    always_comb begin
        pick     = '0;
        idx      = '0;
        any_elig = |elig;
        for (int i = NUM_VOQ - 1; i >= 0; i--) begin
            idx = SRC_W'((int'(rr_ptr) + i) % NUM_VOQ);
            if (elig[idx]) pick = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (state == S_HOLD && ready_i) begin
            rr_ptr <= (grant == SRC_W'(NUM_VOQ - 1)) ? '0 : grant + SRC_W'(1);
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_elig) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = voq_ptr_valid_i[grant] ? S_HOLD : S_IDLE;
            S_HOLD:  if (ready_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        read_req_o = '0;
        valid_o    = 1'b0;
        if (state == S_ISSUE) read_req_o = grant_oh;
        if (state == S_HOLD)  valid_o    = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant   <= '0;
            ptr_o   <= '0;
            flood_o <= 1'b0;
            src_o   <= '0;
            err_o   <= 1'b0;
        end else begin
            if (state == S_IDLE && any_elig) grant <= pick;
            if (state == S_WAIT && voq_ptr_valid_i[grant]) begin
                ptr_o   <= voq_ptr_i[int'(grant) * ADDR_W +: ADDR_W];
                flood_o <= voq_flood_i[grant];
                src_o   <= grant;
            end
            // Protocol errors are sticky until reset.
            if (missing || stray) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_voq_rd_sched.sv
// Bench for voq_rd_sched: VOQ bank model plus queue-based reference scheduler feeding a scoreboard.
`timescale 1ns/1ps
module tb_voq_rd_sched;

    localparam int NUM_VOQ   = 4;
    localparam int ADDR_W    = 8;
    localparam int VOQ_DEPTH = 8;
    localparam int SRC_W     = 2;

    typedef struct packed {logic [ADDR_W-1:0] ptr; logic flood;} entry_t;
    typedef struct packed {logic [ADDR_W-1:0] ptr; logic flood; logic [SRC_W-1:0] src;} exp_t;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_VOQ-1:0]        voq_write_i;
    logic [NUM_VOQ-1:0]        read_req_o;
    logic [NUM_VOQ*ADDR_W-1:0] voq_ptr_i;
    logic [NUM_VOQ-1:0]        voq_ptr_valid_i;
    logic [NUM_VOQ-1:0]        voq_flood_i;
    logic [ADDR_W-1:0]         ptr_o;
    logic                      flood_o;
    logic [SRC_W-1:0]          src_o;
    logic                      valid_o;
    logic                      ready_i;
    logic                      err_o;

    voq_rd_sched #(.NUM_VOQ(NUM_VOQ), .ADDR_W(ADDR_W), .VOQ_DEPTH(VOQ_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .voq_write_i(voq_write_i), .read_req_o(read_req_o),
        .voq_ptr_i(voq_ptr_i), .voq_ptr_valid_i(voq_ptr_valid_i), .voq_flood_i(voq_flood_i),
        .ptr_o(ptr_o), .flood_o(flood_o), .src_o(src_o), .valid_o(valid_o),
        .ready_i(ready_i), .err_o(err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    entry_t voq_q [NUM_VOQ][$];
    exp_t   sb [$];
    int     cnt_model [NUM_VOQ];
    int     snap [NUM_VOQ];
    int     rr_model;
    int     n_checks, n_fail, cyc;

    logic [NUM_VOQ-1:0] wr_mask, stray_mask;
    logic [ADDR_W-1:0]  wr_ptr [NUM_VOQ];
    logic               wr_flood [NUM_VOQ];
    bit                 rdy_ctl, rand_mode, withhold;

    int                 rd_pulses, n_acc, last_wr_cyc, last_rd_cyc, valid_rise_cyc;
    int                 acc_src [$];
    logic [NUM_VOQ-1:0] last_rd_mask;
    logic [ADDR_W-1:0]  last_acc_ptr;
    bit                 wr_rd_same3;

    bit                 resp_pend, prev_hold, prev_acc, prev_valid;
    int                 resp_idx;
    entry_t             resp;
    logic [ADDR_W-1:0]  hold_ptr;
    logic               hold_flood;
    logic [SRC_W-1:0]   hold_src;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arbitration over the occupancy the scheduler saw when it decided.
    function automatic int exp_pick(input int rr);
        for (int i = 0; i < NUM_VOQ; i++) begin
`ifdef VOQ_RD_SCHED_STRICT_PRI_EN
            if (snap[i] > 0) return i;
`else
            if (snap[(rr + i) % NUM_VOQ] > 0) return (rr + i) % NUM_VOQ;
`endif
        end
        return -1;
    endfunction

    // Environment: VOQ bank model, ready driver, reference model and output monitor.
    always @(negedge clk) begin : env
        logic [NUM_VOQ-1:0] rd;
        int                 act, exp_idx;
        exp_t               e;
        entry_t             ent;
        logic               w;
        cyc++;
        rd = read_req_o;
        if (!rst_n) begin
            for (int k = 0; k < NUM_VOQ; k++) begin
                voq_q[k].delete();
                cnt_model[k] = 0;
                snap[k]      = 0;
            end
            sb.delete();
            rr_model        = 0;
            resp_pend       = 0;
            prev_hold       = 0;
            prev_acc        = 0;
            prev_valid      = 0;
            voq_write_i     = '0;
            voq_ptr_valid_i = '0;
            ready_i         = 1'b0;
        end else begin
            ready_i = rand_mode ? ($urandom_range(0, 2) != 0) : rdy_ctl;
            if (prev_hold)
                check("hold_stable", {valid_o, ptr_o, flood_o, src_o, read_req_o},
                      {1'b1, hold_ptr, hold_flood, hold_src, {NUM_VOQ{1'b0}}});
            if (prev_acc) check("valid_drop_after_accept", valid_o, 0);
            if (valid_o && !prev_valid) valid_rise_cyc = cyc;
            prev_valid = valid_o;
            prev_hold  = valid_o && !ready_i;
            prev_acc   = valid_o && ready_i;
            hold_ptr   = ptr_o;
            hold_flood = flood_o;
            hold_src   = src_o;

            if (valid_o && ready_i) begin
                n_acc++;
                acc_src.push_back(int'(src_o));
                last_acc_ptr = ptr_o;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_empty: unexpected output ptr 0x%0h src %0d", ptr_o, src_o);
                end else begin
                    e = sb.pop_front();
                    check("sb_out", {ptr_o, flood_o, src_o}, e);
                    rr_model = (int'(e.src) + 1) % NUM_VOQ;
                end
            end

            // VOQ answers the previous cycle's read with one-cycle latency.
            voq_ptr_valid_i = '0;
            if (resp_pend) begin
                if (withhold) begin
                    if (sb.size() > 0) e = sb.pop_back();
                    withhold = 0;
                end else begin
                    voq_ptr_valid_i[resp_idx]                 = 1'b1;
                    voq_ptr_i[resp_idx * ADDR_W +: ADDR_W]    = resp.ptr;
                    voq_flood_i[resp_idx]                     = resp.flood;
                end
            end
            voq_ptr_valid_i = voq_ptr_valid_i | stray_mask;
            resp_pend = 0;

            if (rd != '0) begin
                act = 0;
                for (int k = 0; k < NUM_VOQ; k++) if (rd[k]) act = k;
                exp_idx = exp_pick(rr_model);
                check("grant_onehot", $onehot(rd), 1);
                check("grant_src", act, exp_idx);
                if (exp_idx >= 0 && voq_q[exp_idx].size() > 0) begin
                    ent = voq_q[exp_idx][0];
                    e   = '{ptr: ent.ptr, flood: ent.flood, src: SRC_W'(exp_idx)};
                    sb.push_back(e);
                end
                if (voq_q[act].size() > 0) resp = voq_q[act].pop_front();
                else                       resp = '0;
                resp_pend    = 1;
                resp_idx     = act;
                rd_pulses++;
                last_rd_mask = rd;
                last_rd_cyc  = cyc;
            end

            for (int k = 0; k < NUM_VOQ; k++) begin
                w = rand_mode ? ($urandom_range(0, 5) == 0) : wr_mask[k];
                voq_write_i[k] = w;
                snap[k] = cnt_model[k];
                if (w && rd[k] && k == 3) wr_rd_same3 = 1;
                if (w && !(cnt_model[k] == VOQ_DEPTH && !rd[k])) begin
                    ent.ptr   = rand_mode ? ADDR_W'($urandom) : wr_ptr[k];
                    ent.flood = rand_mode ? 1'($urandom)      : wr_flood[k];
                    voq_q[k].push_back(ent);
                    cnt_model[k]++;
                end
                if (rd[k]) cnt_model[k]--;
            end
            if (voq_write_i != '0) last_wr_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic burst(input logic [NUM_VOQ-1:0] mask, input int n);
        tick(1);
        wr_mask = mask;
        tick(n);
        wr_mask = '0;
    endtask

    task automatic wait_acc(input int target, input int budget, input string name);
        for (int i = 0; i < budget && n_acc < target; i++) tick(1);
        check(name, n_acc >= target, 1);
    endtask

    task automatic wait_valid(input int budget, input string name);
        for (int i = 0; i < budget && !valid_o; i++) tick(1);
        check(name, valid_o, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base, accb, exp_ord [4], total;
        bit drained;
        rst_n = 1'b0; wr_mask = '0; stray_mask = '0; rdy_ctl = 0; rand_mode = 0; withhold = 0;
        voq_ptr_i = '0; voq_flood_i = '0; voq_write_i = '0; voq_ptr_valid_i = '0; ready_i = 1'b0;
        for (int k = 0; k < NUM_VOQ; k++) begin wr_ptr[k] = '0; wr_flood[k] = 1'b0; end
        tick(3);
        check("rst_valid", valid_o, 0);
        check("rst_read_req", read_req_o, 0);
        check("rst_ptr", ptr_o, 0);
        check("rst_flood", flood_o, 0);
        check("rst_src", src_o, 0);
        check("rst_err", err_o, 0);
        rst_n = 1'b1; rdy_ctl = 1;

        // Single entry in VOQ2.
        wr_ptr[2] = 8'h1A; wr_flood[2] = 1'b0;
        base = rd_pulses; accb = n_acc;
        burst(4'b0100, 1);
        wait_acc(accb + 1, 20, "t1_accept");
        tick(6);
        check("t1_rd_mask", last_rd_mask, 4'b0100);
        check("t1_rd_pulses", rd_pulses - base, 1);
        check("t1_rd_cycle", last_rd_cyc - last_wr_cyc, 2);
        check("t1_latency", valid_rise_cyc - (last_wr_cyc + 1), 3);
        check("t1_ptr", last_acc_ptr, 8'h1A);
        check("t1_src", acc_src[accb], 2);

        // Two entries each in VOQ0 and VOQ1.
        for (int k = 0; k < NUM_VOQ; k++) begin wr_ptr[k] = ADDR_W'(8'h20 + k); wr_flood[k] = k[0]; end
`ifdef VOQ_RD_SCHED_STRICT_PRI_EN
        exp_ord = '{0, 0, 1, 1};
`else
        exp_ord = '{0, 1, 0, 1};
`endif
        accb = n_acc;
        burst(4'b0011, 2);
        wait_acc(accb + 4, 60, "t2_accept");
        for (int i = 0; i < 4; i++) check($sformatf("t2_order%0d", i), acc_src[accb + i], exp_ord[i]);

        // Egress stall while a pointer is presented.
        rdy_ctl = 0;
        wr_ptr[3] = 8'h5C; wr_flood[3] = 1'b1;
        burst(4'b1000, 1);
        wait_valid(20, "t3_valid");
        base = rd_pulses;
        tick(5);
        check("t3_no_read", rd_pulses - base, 0);
        check("t3_still_valid", valid_o, 1);
        rdy_ctl = 1;
        tick(1);
        check("t3_drop", valid_o, 0);
        tick(4);

        // Write to VOQ3 in the cycle its only entry is being read.
        accb = n_acc; wr_rd_same3 = 0;
        tick(1); wr_mask = 4'b1000;
        tick(1); wr_mask = '0;
        tick(1); wr_mask = 4'b1000;
        tick(1); wr_mask = '0;
        wait_acc(accb + 2, 40, "t4_accept");
        check("t4_same_cycle", wr_rd_same3, 1);
        check("t4_src_a", acc_src[accb], 3);
        check("t4_src_b", acc_src[accb + 1], 3);
        tick(4);

        // VOQ fails to answer.
        accb = n_acc; withhold = 1;
        burst(4'b0010, 1);
        tick(8);
        check("t5_err", err_o, 1);
        check("t5_no_output", n_acc - accb, 0);
        burst(4'b0100, 1);
        wait_acc(accb + 1, 20, "t5_recover");
        check("t5_err_sticky", err_o, 1);

        // Stray pointer valid while idle.
        rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
        check("t6_err_clear", err_o, 0);
        stray_mask = 4'b0010; tick(1); stray_mask = '0; tick(1);
        check("t6_stray_err", err_o, 1);

        // Overfill VOQ0 while egress stalls.
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        rdy_ctl = 0; accb = n_acc;
        burst(4'b0001, VOQ_DEPTH + 2);
        tick(3);
        rdy_ctl = 1;
        wait_acc(accb + VOQ_DEPTH + 1, 120, "t7_accept");
        tick(10);
        check("t7_total", n_acc - accb, VOQ_DEPTH + 1);

        // Reset while holding a pointer.
        rdy_ctl = 0;
        burst(4'b0001, 3);
        wait_valid(20, "t8_valid");
        base = rd_pulses;
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        check("t8_valid_rst", valid_o, 0);
        check("t8_ptr_rst", ptr_o, 0);
        rdy_ctl = 1;
        tick(10);
        check("t8_counts_clear", rd_pulses - base, 0);

        // Random traffic, then drain.
        accb = n_acc;
        rand_mode = 1;
        tick(400);
        rand_mode = 0;
        drained = 0;
        for (int i = 0; i < 600 && !drained; i++) begin
            tick(1);
            total = 0;
            for (int k = 0; k < NUM_VOQ; k++) total += cnt_model[k];
            drained = (total == 0) && (sb.size() == 0) && !valid_o;
        end
        check("rand_drained", drained, 1);
        check("rand_traffic", (n_acc - accb) > 20, 1);
        check("rand_err", err_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
